// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the ALU controller and the
// iterative unit, plus the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1100;

    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations; shifts and unknown codes produce 0 here and are
// handled by the iterative sequencer in the parent.
module alu_comb
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_ADD: y_o = a_i + b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_EQ:  y_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
            OP_SLT: y_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter_unit.sv
// ALU with a one-bit-per-cycle shifter: single-cycle ops finish in one edge,
// shifts by n take n extra edges. Valid/ready handshake on both sides.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero,
    output logic              busy
);

    alu_state_e          state_q, state_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   comb_y;
    logic [SHAMT_W-1:0]  shamt;

    assign shamt = SrcB[SHAMT_W-1:0];

    alu_comb #(.DATA_W(DATA_W)) u_comb (
        .op_i (Operation),
        .a_i  (SrcA),
        .b_i  (SrcB),
        .y_o  (comb_y)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d = Operation;
                        if (is_shift_op(Operation)) begin
                            res_d = SrcA;
                            if (shamt != '0) begin
                                cnt_d   = shamt;
                                state_d = ST_SHIFT;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            res_d   = comb_y;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    // SRA: the MSB never changes while shifting right, so it
                    // still holds the original SrcA[31] on every step.
                    case (op_q)
                        OP_SLL:  res_d = {res_q[DATA_W-2:0], 1'b0};
                        OP_SRL:  res_d = {1'b0, res_q[DATA_W-1:1]};
                        default: res_d = {res_q[DATA_W-1], res_q[DATA_W-1:1]};
                    endcase
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_AND;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign ALUResult = res_q;
    assign Zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_iter_unit.sv
// Directed bench for alu_iter_unit: latency, results, backpressure, flush and
// mid-operation reset against hand-computed values.
module tb_alu_iter_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA, SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_iter_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present an op for one accept edge, then scramble inputs (must be ignored).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        Operation = 4'b0110; SrcA = 32'hDEAD_BEEF; SrcB = 32'h0000_0013;
    endtask

    // Called #1 after the accept edge; lat counts edges including the accept edge.
    task automatic wait_valid(output int lat, output int rdy_bad);
        lat = 1; rdy_bad = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) rdy_bad++;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, bad;
        issue(op, a, b);
        wait_valid(lat, bad);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, ALUResult, exp);
        chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
        chk({tag, "_rdy_low"}, bad, 0);
        @(posedge clk); #1;
        chk({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int lat, bad;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Operation = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        #4 reset_n = 1'b1;

        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("add",      4'b0010, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1);
        run_op("and",      4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1);
        run_op("or",       4'b0001, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1);
        run_op("xor",      4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
        run_op("slt_neg",  4'b1100, 32'hFFFF_FFFE, 32'h1, 32'h1, 1);
        run_op("slt_pos",  4'b1100, 32'h1, 32'hFFFF_FFFE, 32'h0, 1);
        run_op("eq_same",  4'b1000, 32'h1234, 32'h1234, 32'h1, 1);
        run_op("eq_diff",  4'b1000, 32'h1234, 32'h1235, 32'h0, 1);
        run_op("bad_op",   4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("sll_0",    4'b0100, 32'hCAFE_0001, 32'hFFFF_FFE0, 32'hCAFE_0001, 1);
        run_op("sra_4",    4'b0111, 32'h8000_0000, 32'h4, 32'hF800_0000, 5);
        run_op("sra_pos",  4'b0111, 32'h7FFF_FFFF, 32'h3, 32'h0FFF_FFFF, 4);
        run_op("srl_31",   4'b0101, 32'h8000_0000, 32'h1F, 32'h1, 32);
        run_op("sll_8",    4'b0100, 32'h00AB_CDEF, 32'h8, 32'hABCD_EF00, 9);

        // Backpressure: consumer stalls 3 cycles after out_valid.
        out_ready = 1'b0;
        issue(4'b0100, 32'h1, 32'd31);
        wait_valid(lat, bad);
        chk("bp_lat", lat, 32);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_res", ALUResult, 32'h8000_0000);
            chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);

        // Flush two cycles into a long SRL, with a new request on the same edge.
        issue(4'b0101, 32'hFFFF_0000, 32'd20);
        @(posedge clk); #1;
        chk("fl_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1; in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd2; SrcB = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_idle", {30'd0, busy, in_ready}, 32'd1);
        chk("fl_no_valid", {31'd0, out_valid}, 32'd0);
        bad = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid || busy) bad++;
        end
        chk("fl_no_result", bad, 0);

        // Flush beats result hand-off in DONE.
        out_ready = 1'b0;
        issue(4'b0010, 32'd7, 32'd8);
        chk("fl_done_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_done_drop", {30'd0, out_valid, in_ready}, 32'd1);

        // Asynchronous reset in the middle of a shift.
        issue(4'b0111, 32'h8000_00F0, 32'd10);
        repeat (3) @(posedge clk);
        #1;
        chk("mr_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_result", ALUResult, 32'd0);
        chk("mr_zero", {31'd0, Zero}, 32'd1);
        #3 reset_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid || busy) bad++;
        end
        chk("mr_no_spurious", bad, 0);

        // First rising edge after release accepts a waiting request.
        @(posedge clk); #1;
        reset_n = 1'b0;
        in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd2; SrcB = 32'd3;
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rel_accept_valid", {31'd0, out_valid}, 32'd1);
        chk("rel_accept_res", ALUResult, 32'd5);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_iter_unit.md
ALU_ITER_UNIT -- requirements
Module: alu_iter_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-005 SHALL have port in_valid  input  1  operands and Operation are valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept; high only in IDLE.
REQ-007 SHALL have port Operation  input  4  ALU operation code from the ALU controller.
REQ-008 SHALL have ports SrcA and SrcB  input  DATA_W  operands; SrcB[4:0] is the shift amount.
REQ-009 SHALL have port out_valid  output  1  ALUResult/Zero are valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have ports ALUResult  output  DATA_W  and Zero  output  1  (Zero = ALUResult==0).
REQ-012 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-013 SHALL decode Operation: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA, 1000 EQ (result 1 if SrcA==SrcB, else 0), 1100 SLT (signed, result 1/0); any other code yields result 0 as a single-cycle operation.
REQ-014 SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-015 SHALL accept an operation on a rising edge where in_valid && in_ready && !flush.
REQ-016 SHALL, on accept of a non-shift op, register the result and enter DONE, so out_valid is high in the next cycle (latency 1).
REQ-017 SHALL, on accept of a shift op with shamt n>0, load SrcA and n, enter SHIFT, and shift one bit per edge; the n-th shift edge enters DONE (out_valid visible n+1 cycles after accept).
REQ-018 SHALL treat a shift with shamt 0 as single-cycle, with result SrcA.
REQ-019 SHALL fill vacated SRA bits with the original SrcA[31]; SLL/SRL SHALL fill with 0.
REQ-020 SHALL perform ADD modulo 2^32 with no carry or overflow output.
REQ-021 SHALL hold ALUResult, Zero and out_valid stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-022 SHALL keep in_ready low in SHIFT and DONE; there is no overlap of accept with result hand-off.
REQ-023 SHALL, on flush in any state, enter IDLE on that edge, discard the result and drop out_valid next cycle; flush has priority over accept and over result hand-off.
REQ-024 SHALL ignore Operation/SrcA/SrcB changes after accept.

Reset
REQ-025 SHALL, while reset_n is low, force state IDLE, ALUResult 0, shift counter 0, out_valid 0, busy 0; Zero reads 1 and in_ready reads 1.
REQ-026 SHALL abandon any in-flight operation on reset assertion mid-operation; no result is produced after release.
REQ-027 SHALL first accept on the first rising edge after reset_n deasserts with in_valid high.

Structure
REQ-028 SHALL take the Operation code constants and the FSM state enum from shared package alu_pkg, also used by the ALU controller.
REQ-029 SHALL place single-cycle ops (AND/OR/ADD/XOR/EQ/SLT) in combinational sub-module alu_comb; the shift sequencer and FSM stay in alu_iter_unit.

Verification
REQ-030 SHALL cover ADD: 0010, A=0xFFFFFFFF, B=1 -> out_valid the cycle after accept, ALUResult 0, Zero 1.
REQ-031 SHALL cover SRA: 0111, A=0x80000000, B=4 -> out_valid 5 cycles after accept, ALUResult 0xF8000000; in_ready low throughout.
REQ-032 SHALL cover SLT: 1100, A=0xFFFFFFFE, B=1 -> ALUResult 1; EQ 1000 with A=B=0x1234 -> ALUResult 1.
REQ-033 SHALL cover backpressure: SLL A=1, B=31 with out_ready low 3 cycles after out_valid -> 0x80000000 held stable, released on the out_ready edge, in_ready high next cycle.
REQ-034 SHALL cover flush: assert flush 2 cycles into SRL B=20, with in_valid high on the same edge -> IDLE, no out_valid, no accept that edge.
REQ-035 SHALL cover mid-operation reset: reset_n low during SHIFT -> all outputs at reset values immediately; no spurious out_valid after release.
